// File: rtl/eth_pkg.sv
// Shared types and constants for the MII receive/transmit path: FSM state,
// preamble/SFD nibble codes and CRC-32 parameters.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_HI_NIBBLE   = 4'hD;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

    // The CRC register runs LSB-first, so constants are mirrored before use.
    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_nibble.sv
// Combinational reflected CRC-32 step over one nibble (LSB first).
// Shared by the receive FCS checker and the nibble transmitter.
module eth_crc32_nibble
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [3:0]  i_nibble,
    output logic [31:0] o_crc
);
    localparam logic [31:0] POLY_REFL = bit_reverse32(CRC32_POLY);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {28'd0, i_nibble};
        for (int i = 0; i < 4; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ POLY_REFL) : (w_crc >> 1);
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/ethernet_rx.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes and marks
// sof/eof/err. Define ETH_RX_FCS_CHECK_EN to add the CRC-32 FCS check.
module ethernet_rx
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_BYTES      = 1522,
    parameter int MIN_PREAMBLE_NIBBLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rxd,
    input  logic       rx_dv,
    input  logic       rx_er,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sof_out,
    output logic       eof_out,
    output logic       err_out,
    output logic       fcs_ok_out
);
    localparam logic [15:0] MAX_BYTES_CNT = 16'(MAX_FRAME_BYTES);

    rx_state_e   r_state;
    rx_state_e   w_next_state;
    logic [3:0]  r_pre_cnt;
    logic        r_phase;
    logic [3:0]  r_lo;
    logic [7:0]  r_held;
    logic        r_have_held;
    logic [15:0] r_byte_cnt;
    logic        r_err_sticky;

    logic w_is_pre, w_is_sfd, w_pre_ok, w_in_data, w_sfd_accept;
    logic w_byte_done, w_overflow, w_frame_end;
    logic w_emit, w_sof, w_eof, w_err, w_fcs_ok;

    assign w_is_pre     = (rxd == PREAMBLE_NIBBLE);
    assign w_is_sfd     = (rxd == SFD_HI_NIBBLE);
    assign w_pre_ok     = (int'(r_pre_cnt) >= MIN_PREAMBLE_NIBBLES);
    assign w_in_data    = (r_state == ST_DATA);
    assign w_sfd_accept = (r_state == ST_PREAMBLE) && (w_next_state == ST_DATA);
    assign w_byte_done  = w_in_data && rx_dv && r_phase;
    assign w_overflow   = w_byte_done && (r_byte_cnt == MAX_BYTES_CNT);
    assign w_frame_end  = w_in_data && !rx_dv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:     if (rx_dv) w_next_state = w_is_pre ? ST_PREAMBLE : ST_DROP;
            ST_PREAMBLE: begin
                if (!rx_dv)                     w_next_state = ST_IDLE;
                else if (w_is_pre)              w_next_state = ST_PREAMBLE;
                else if (w_is_sfd && w_pre_ok)  w_next_state = ST_DATA;
                else                            w_next_state = ST_DROP;
            end
            ST_DATA: begin
                if (!rx_dv)          w_next_state = ST_IDLE;
                else if (w_overflow) w_next_state = ST_DROP;
            end
            ST_DROP:     if (!rx_dv) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // The held byte leaves when its successor completes or the frame ends.
    always_comb begin
        w_emit = 1'b0;
        w_eof  = 1'b0;
        w_err  = 1'b0;
        if (w_frame_end) begin
            w_emit = r_have_held;
            w_eof  = 1'b1;
            w_err  = r_err_sticky | r_phase;
        end else if (w_byte_done) begin
            w_emit = r_have_held;
            w_eof  = w_overflow;
            w_err  = w_overflow;
        end
        w_sof = (r_byte_cnt == 16'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt    <= '0;
            r_phase      <= 1'b0;
            r_lo         <= '0;
            r_held       <= '0;
            r_have_held  <= 1'b0;
            r_byte_cnt   <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (r_state == ST_IDLE)
                r_pre_cnt <= 4'd1;
            else if (r_state == ST_PREAMBLE && rx_dv && w_is_pre && r_pre_cnt != 4'hF)
                r_pre_cnt <= r_pre_cnt + 4'd1;

            if (w_sfd_accept) begin
                r_phase      <= 1'b0;
                r_have_held  <= 1'b0;
                r_byte_cnt   <= '0;
                r_err_sticky <= 1'b0;
            end else if (w_in_data && rx_dv) begin
                r_phase <= ~r_phase;
                if (rx_er) r_err_sticky <= 1'b1;
                if (!r_phase) begin
                    r_lo <= rxd;
                end else if (!w_overflow) begin
                    r_held      <= {rxd, r_lo};
                    r_have_held <= 1'b1;
                    r_byte_cnt  <= r_byte_cnt + 16'd1;
                end
            end
        end
    end

`ifdef ETH_RX_FCS_CHECK_EN
    localparam logic [31:0] RESIDUE_REFL = bit_reverse32(CRC32_RESIDUE);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    eth_crc32_nibble u_crc (
        .i_crc    (r_crc),
        .i_nibble (rxd),
        .o_crc    (w_crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_crc <= CRC32_INIT;
        else if (w_sfd_accept)     r_crc <= CRC32_INIT;
        else if (w_in_data && rx_dv) r_crc <= w_crc_next;
    end

    assign w_fcs_ok = (r_crc == RESIDUE_REFL);
`else
    assign w_fcs_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            sof_out    <= 1'b0;
            eof_out    <= 1'b0;
            err_out    <= 1'b0;
            fcs_ok_out <= 1'b0;
        end else begin
            valid_out  <= w_emit;
            sof_out    <= w_emit & w_sof;
            eof_out    <= w_emit & w_eof;
            err_out    <= w_emit & w_eof & w_err;
            fcs_ok_out <= w_emit & w_eof & ~w_err & w_fcs_ok;
            if (w_emit) data_out <= r_held;
        end
    end

endmodule

// File: tb/tb_ethernet_rx.sv
// Scoreboard bench for ethernet_rx: two instances (default and MAX_FRAME_BYTES=4)
// share one nibble stream; a frame-level model fills per-instance expected queues.
`timescale 1ns/1ps
module tb_ethernet_rx;

    localparam int BIG_MAX   = 1522;
    localparam int SMALL_MAX = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        logic       fcs;
    } exp_t;

    typedef logic [7:0] bq_t[$];

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rxd   = 4'h0;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;

    logic [7:0] data_o  [2];
    logic       valid_o [2];
    logic       sof_o   [2];
    logic       eof_o   [2];
    logic       err_o   [2];
    logic       fcs_o   [2];

    exp_t       exp_q [2][$];
    logic [7:0] last_data [2];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    ethernet_rx #(.MAX_FRAME_BYTES(BIG_MAX)) dut_big (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .data_out(data_o[0]), .valid_out(valid_o[0]), .sof_out(sof_o[0]),
        .eof_out(eof_o[0]), .err_out(err_o[0]), .fcs_ok_out(fcs_o[0])
    );

    ethernet_rx #(.MAX_FRAME_BYTES(SMALL_MAX)) dut_small (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .data_out(data_o[1]), .valid_out(valid_o[1]), .sof_out(sof_o[1]),
        .eof_out(eof_o[1]), .err_out(err_o[1]), .fcs_ok_out(fcs_o[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    // Standard reflected CRC-32 over whole bytes, returning the FCS value.
    function automatic logic [31:0] fcs32(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    function automatic bq_t with_fcs(input bq_t b);
        bq_t r;
        logic [31:0] f;
        r = b;
        f = fcs32(b, b.size());
        for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
        return r;
    endfunction

    // Frame-level expectation: b holds every completed byte sent after the SFD.
    task automatic model_frame(input bq_t b, input bit accepted, input bit odd,
                               input bit er, input bit aborted);
        int   n, lim, k;
        bit   trunc, last_eof, bad, fcs_good;
        exp_t e;
        n = b.size();
        for (int m = 0; m < 2; m++) begin
            lim = (m == 0) ? BIG_MAX : SMALL_MAX;
            if (accepted) begin
                trunc    = (n > lim);
                k        = trunc ? lim : (aborted ? n - 1 : n);
                last_eof = trunc || !aborted;
                bad      = trunc || er || odd;
                fcs_good = 1'b0;
`ifdef ETH_RX_FCS_CHECK_EN
                if (!bad && n >= 4)
                    fcs_good = (fcs32(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]});
`endif
                for (int i = 0; i < k; i++) begin
                    e.data = b[i];
                    e.sof  = (i == 0);
                    e.eof  = last_eof && (i == k - 1);
                    e.err  = e.eof && bad;
                    e.fcs  = e.eof && fcs_good;
                    exp_q[m].push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
    endtask

    task automatic send_frame(input int pre_n, input int bad_pos, input logic [3:0] sfd,
                              input bq_t b, input bit odd, input int er_nib, input int gap);
        bit accepted;
        int n;
        n = b.size();
        accepted = (pre_n >= 2) && (sfd == 4'hD) && (bad_pos < 0 || bad_pos >= pre_n);
        model_frame(b, accepted, odd, (er_nib >= 0) && (er_nib < 2*n + int'(odd)), 1'b0);
        for (int i = 0; i < pre_n; i++) drive(1'b1, (i == bad_pos) ? 4'h3 : 4'h5, 1'($urandom));
        drive(1'b1, sfd, 1'($urandom));
        for (int i = 0; i < n; i++) begin
            drive(1'b1, b[i][3:0], er_nib == 2*i);
            drive(1'b1, b[i][7:4], er_nib == 2*i + 1);
        end
        if (odd) drive(1'b1, 4'($urandom), er_nib == 2*n);
        for (int i = 0; i < gap; i++) drive(1'b0, 4'($urandom), 1'($urandom));
    endtask

    // Monitor: pops one expectation per valid_out pulse, polices idle outputs.
    initial begin
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (valid_o[m]) begin
                    if (exp_q[m].size() == 0) begin
                        check($sformatf("dut%0d_unexpected_valid", m), {31'd0, valid_o[m]}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q[m].pop_front();
                        check($sformatf("dut%0d_byte{data,sof,eof,err,fcs}", m),
                              {20'd0, data_o[m], sof_o[m], eof_o[m], err_o[m], fcs_o[m]},
                              {20'd0, e});
                        last_data[m] = e.data;
                    end
                end else begin
                    if ({sof_o[m], eof_o[m], err_o[m], fcs_o[m]} != 4'd0)
                        check($sformatf("dut%0d_flags_when_idle", m),
                              {28'd0, sof_o[m], eof_o[m], err_o[m], fcs_o[m]}, 32'd0);
                    if (data_o[m] != last_data[m])
                        check($sformatf("dut%0d_data_hold", m), {24'd0, data_o[m]}, {24'd0, last_data[m]});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        bq_t b5;

        #1;
        for (int m = 0; m < 2; m++)
            check($sformatf("dut%0d_reset_outputs", m),
                  {21'd0, data_o[m], valid_o[m], sof_o[m], eof_o[m], err_o[m]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Long preamble, three bytes.
        b = '{8'h11, 8'h22, 8'h33};
        send_frame(15, -1, 4'hD, b, 1'b0, -1, 2);
        // Single byte, zero-byte frame, lone low nibble.
        b = '{8'hA5};
        send_frame(7, -1, 4'hD, b, 1'b0, -1, 2);
        b = {};
        send_frame(7, -1, 4'hD, b, 1'b0, -1, 2);
        send_frame(7, -1, 4'hD, b, 1'b1, -1, 2);
        // Odd nibble count after bytes.
        send_frame(7, -1, 4'hD, rand_bytes(3), 1'b1, -1, 2);
        // rx_er mid-payload of a 4-byte frame.
        send_frame(7, -1, 4'hD, rand_bytes(4), 1'b0, 3, 2);
        // Broken preamble, then a good frame.
        send_frame(6, 2, 4'hD, rand_bytes(3), 1'b0, -1, 2);
        send_frame(6, -1, 4'hD, rand_bytes(3), 1'b0, -1, 2);
        // Preamble length boundary: one 0x5 too few, then exactly enough.
        send_frame(1, -1, 4'hD, rand_bytes(2), 1'b0, -1, 2);
        send_frame(2, -1, 4'hD, rand_bytes(2), 1'b0, -1, 2);
        // Six bytes: the small instance truncates after four.
        send_frame(7, -1, 4'hD, rand_bytes(6), 1'b0, -1, 2);
        // 60-byte frame with valid FCS, then with one payload bit flipped.
        b = with_fcs(rand_bytes(56));
        send_frame(7, -1, 4'hD, b, 1'b0, -1, 2);
        b[10] = b[10] ^ 8'h04;
        send_frame(7, -1, 4'hD, b, 1'b0, -1, 2);
        // Large frame boundary: exactly the limit, then one byte over.
        send_frame(7, -1, 4'hD, with_fcs(rand_bytes(BIG_MAX - 4)), 1'b0, -1, 2);
        send_frame(7, -1, 4'hD, rand_bytes(BIG_MAX + 1), 1'b0, -1, 2);

        // Reset mid-frame: five bytes complete, a sixth begun.
        b5 = rand_bytes(5);
        model_frame(b5, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, b5[i][3:0], 1'b0);
            drive(1'b1, b5[i][7:4], 1'b0);
        end
        drive(1'b1, 4'h6, 1'b0);
        @(negedge clk);
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        rst_n = 1'b0;
        rx_dv = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("dut%0d_midframe_reset_outputs", m),
                  {21'd0, data_o[m], valid_o[m], sof_o[m], eof_o[m], err_o[m]}, 32'd0);
            check($sformatf("dut%0d_pending_before_reset", m), exp_q[m].size(), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8, -1, 4'hD, rand_bytes(5), 1'b0, -1, 2);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            int pre_n, bad_pos, len, er_nib;
            logic [3:0] sfd;
            bit odd;
            pre_n   = $urandom_range(0, 20);
            bad_pos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, pre_n)) : -1;
            sfd     = ($urandom_range(0, 7) == 0) ? 4'h7 : 4'hD;
            len     = $urandom_range(0, 10);
            b       = rand_bytes(len);
            if ($urandom_range(0, 1) == 1) b = with_fcs(b);
            odd     = ($urandom_range(0, 4) == 0);
            er_nib  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2*b.size())) : -1;
            send_frame(pre_n, bad_pos, sfd, b, odd, er_nib, $urandom_range(1, 3));
        end

        repeat (10) @(negedge clk);
        for (int m = 0; m < 2; m++)
            check($sformatf("dut%0d_leftover_expected", m), exp_q[m].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
